// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
// Serial-load matrix multiply engine: R = W x X, with matrices up to
// MAX_DIM x MAX_DIM of unsigned DATA_W-bit elements.
// W is streamed in one element per clock, then X, both row-major. After one
// compute edge, R is streamed out row-major on res, one element per clock.
// There is no handshake; the producer is cycle-aligned to the load sequence.
//
// Ports
//   res        out RES_W   serial result element (registered, 0 outside UNLOAD)
//   data_in    in  DATA_W  serial matrix element input
//   clk        in  1       clock, all state updates on posedge
//   clear_mem  in  1       synchronous active-high reset
//   row_w      in  DIM_W   rows of W
//   row_x      in  DIM_W   rows of X
//   col_w      in  DIM_W   cols of W (inner dimension)
//   col_x      in  DIM_W   cols of X
// -----------------------------------------------------------------------------
module datapath #(
  parameter int DATA_W = 4,
  parameter int DIM_W  = 2,
  parameter int RES_W  = 10
) (
  output logic [RES_W-1:0]  res,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clk,
  input  logic              clear_mem,
  input  logic [DIM_W-1:0]  row_w,
  input  logic [DIM_W-1:0]  row_x,
  input  logic [DIM_W-1:0]  col_w,
  input  logic [DIM_W-1:0]  col_x
);

  localparam int MAX_DIM = (1 << DIM_W) - 1;

  typedef enum logic [2:0] {
    LOAD_W  = 3'd0,
    LOAD_X  = 3'd1,
    COMPUTE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // One product term, zero-extended to the result width. The full-width sum
  // of up to MAX_DIM such terms cannot wrap for the configured widths.
  function automatic logic [RES_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = a * b;
    return RES_W'(p);
  endfunction

  // Row-major index walk over a rows x cols grid.
  // Returns {last, next_i, next_j}; wraps to (0,0) after the final element.
  function automatic logic [2*DIM_W:0] next_idx(input logic [DIM_W-1:0] i,
                                                input logic [DIM_W-1:0] j,
                                                input logic [DIM_W-1:0] rows,
                                                input logic [DIM_W-1:0] cols);
    if (j == cols - DIM_W'(1)) begin
      if (i == rows - DIM_W'(1)) begin
        return {1'b1, DIM_W'(0), DIM_W'(0)};
      end
      return {1'b0, i + DIM_W'(1), DIM_W'(0)};
    end
    return {1'b0, i, j + DIM_W'(1)};
  endfunction

  // State and storage
  state_t              state_q, state_d;
  logic [DIM_W-1:0]    i_q, i_d;
  logic [DIM_W-1:0]    j_q, j_d;
  logic                dim_vld_q, dim_vld_d;
  logic [DIM_W-1:0]    rw_q, rw_d, cw_q, cw_d, rx_q, rx_d, cx_q, cx_d;
  logic [DATA_W-1:0]   w_q [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0]   w_d [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0]   x_q [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0]   x_d [MAX_DIM][MAX_DIM];
  logic [RES_W-1:0]    r_q [MAX_DIM][MAX_DIM];
  logic [RES_W-1:0]    r_d [MAX_DIM][MAX_DIM];
  logic [RES_W-1:0]    res_q, res_d;

  // Working signals
  logic [DIM_W-1:0]    rw, cw, rx, cx;
  logic                nw_zero, nx_zero, nr_zero;
  state_t              eff_state;
  logic [2*DIM_W:0]    step;
  logic [RES_W-1:0]    acc;

  assign res = res_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    dim_vld_d = 1'b1;
    rw_d      = rw_q;
    cw_d      = cw_q;
    rx_d      = rx_q;
    cx_d      = cx_q;
    w_d       = w_q;
    x_d       = x_q;
    r_d       = r_q;
    res_d     = '0;
    step      = '0;
    acc       = '0;

    // The first edge after reset uses the live dimension inputs and latches
    // them; every later edge of the sequence uses the latched copy.
    if (dim_vld_q) begin
      rw = rw_q;
      cw = cw_q;
      rx = rx_q;
      cx = cx_q;
    end else begin
      rw   = row_w;
      cw   = col_w;
      rx   = row_x;
      cx   = col_x;
      rw_d = row_w;
      cw_d = col_w;
      rx_d = row_x;
      cx_d = col_x;
    end

    nw_zero = (rw == '0) || (cw == '0);
    nx_zero = (rx == '0) || (cx == '0);
    nr_zero = (rw == '0) || (cx == '0);

    // Empty load phases are skipped without spending an edge: the edge is
    // handled by whichever phase comes next.
    eff_state = state_q;
    if (eff_state == LOAD_W && nw_zero) eff_state = LOAD_X;
    if (eff_state == LOAD_X && nx_zero) eff_state = COMPUTE;

    unique case (eff_state)
      LOAD_W: begin
        w_d[i_q][j_q] = data_in;
        step = next_idx(i_q, j_q, rw, cw);
        {i_d, j_d} = step[2*DIM_W-1:0];
        if (step[2*DIM_W]) state_d = LOAD_X;
        else               state_d = LOAD_W;
      end
      LOAD_X: begin
        x_d[i_q][j_q] = data_in;
        step = next_idx(i_q, j_q, rx, cx);
        {i_d, j_d} = step[2*DIM_W-1:0];
        state_d = step[2*DIM_W] ? COMPUTE : LOAD_X;
      end
      COMPUTE: begin
        // X rows at or beyond rx were never loaded and contribute 0 when the
        // inner dimensions disagree.
        for (int ii = 0; ii < MAX_DIM; ii++) begin
          for (int jj = 0; jj < MAX_DIM; jj++) begin
            acc = '0;
            for (int kk = 0; kk < MAX_DIM; kk++) begin
              if (DIM_W'(kk) < cw && DIM_W'(kk) < rx) begin
                acc = acc + mac_term(w_q[ii][kk], x_q[kk][jj]);
              end
            end
            r_d[ii][jj] = acc;
          end
        end
        i_d     = '0;
        j_d     = '0;
        state_d = nr_zero ? DONE : UNLOAD;
      end
      UNLOAD: begin
        res_d = r_q[i_q][j_q];
        step  = next_idx(i_q, j_q, rw, cx);
        {i_d, j_d} = step[2*DIM_W-1:0];
        state_d = step[2*DIM_W] ? DONE : UNLOAD;
      end
      default: begin
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_mem) begin
      state_q   <= LOAD_W;
      i_q       <= '0;
      j_q       <= '0;
      dim_vld_q <= 1'b0;
      rw_q      <= '0;
      cw_q      <= '0;
      rx_q      <= '0;
      cx_q      <= '0;
      w_q       <= '{default: '0};
      x_q       <= '{default: '0};
      r_q       <= '{default: '0};
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      dim_vld_q <= dim_vld_d;
      rw_q      <= rw_d;
      cw_q      <= cw_d;
      rx_q      <= rx_d;
      cx_q      <= cx_d;
      w_q       <= w_d;
      x_q       <= x_d;
      r_q       <= r_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic       clk = 1'b0;
  logic       clear_mem;
  logic [3:0] data_in;
  logic [1:0] row_w, row_x, col_w, col_x;
  logic [9:0] res;

  int n_checks = 0;
  int n_pass   = 0;
  int stim_q[$];
  int exp_q[$];

  datapath dut (
    .res       (res),
    .data_in   (data_in),
    .clk       (clk),
    .clear_mem (clear_mem),
    .row_w     (row_w),
    .row_x     (row_x),
    .col_w     (col_w),
    .col_x     (col_x)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one posedge and settle so res reflects that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset (edge 0), stream stim_q, one compute edge, then nunl unload edges
  // compared against exp_q. A full unload is followed by DONE checks.
  task automatic run_case(input string name, input int rw, input int cw,
                          input int rx, input int cx, input int nunl);
    int nw, nx, nr;
    nw = rw * cw;
    nx = rx * cx;
    nr = rw * cx;
    clear_mem = 1'b1;
    data_in   = 4'd0;
    row_w = 2'(rw); col_w = 2'(cw); row_x = 2'(rx); col_x = 2'(cx);
    tick();
    check({name, "_reset"}, res, 0);
    clear_mem = 1'b0;
    for (int e = 0; e < nw + nx; e++) begin
      data_in = 4'(stim_q[e]);
      tick();
      if (e == 0) begin
        // Dimensions must already be latched; disturb the inputs.
        row_w = ~row_w; col_w = ~col_w; row_x = ~row_x; col_x = ~col_x;
      end
      check($sformatf("%s_load%0d", name, e + 1), res, 0);
    end
    data_in = 4'hF;
    tick();
    check({name, "_compute"}, res, 0);
    for (int u = 0; u < nunl; u++) begin
      data_in = 4'($urandom_range(0, 15));
      tick();
      check($sformatf("%s_r%0d", name, u), res, exp_q[u]);
    end
    if (nunl == nr) begin
      for (int d = 0; d < 3; d++) begin
        data_in = 4'($urandom_range(0, 15));
        tick();
        check($sformatf("%s_done%0d", name, d), res, 0);
      end
    end
  endtask

  initial begin
    clear_mem = 1'b1;
    data_in   = '0;
    row_w = '0; row_x = '0; col_w = '0; col_x = '0;
    tick();
    tick();
    check("por_reset", res, 0);

    // 3x2 * 2x3
    stim_q = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    exp_q  = '{41, 45, 49, 87, 96, 105, 125, 138, 151};
    run_case("m3x2", 3, 2, 2, 3, 9);

    // 2x2 identity
    stim_q = '{1, 0, 0, 1, 1, 0, 0, 1};
    exp_q  = '{1, 0, 0, 1};
    run_case("ident", 2, 2, 2, 2, 4);

    // 1x1
    stim_q = '{10, 15};
    exp_q  = '{150};
    run_case("one", 1, 1, 1, 1, 1);

    // Overflow bound: all 15
    stim_q = '{15, 15, 15, 15, 15, 15, 15, 15, 15,
               15, 15, 15, 15, 15, 15, 15, 15, 15};
    exp_q  = '{675, 675, 675, 675, 675, 675, 675, 675, 675};
    run_case("max", 3, 3, 3, 3, 9);

    // Inner-dimension mismatch: missing X row reads as 0
    stim_q = '{2, 3, 4};
    exp_q  = '{8};
    run_case("mism", 1, 2, 1, 1, 1);

    // Reset during UNLOAD of 3x2, then 1x1 reload
    stim_q = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    exp_q  = '{41, 45, 49, 87, 96, 105, 125, 138, 151};
    run_case("abort", 3, 2, 2, 3, 3);
    stim_q = '{10, 15};
    exp_q  = '{150};
    run_case("reload", 1, 1, 1, 1, 1);

    // Zero-row W: W phase skipped, no results
    stim_q = '{7};
    exp_q  = '{0};
    run_case("zero", 0, 1, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
